aes_apb_dma_master: RTL
=======================

Name: aes_apb_dma_master

Overview:
- APB requester that services the AES peripheral's DMA request pair and moves one 128-bit block per request as BLOCK_WORDS 32-bit APB transfers.
- Write direction: words come from a source stream and are written to the AES data-input register.
- Read direction: words are read from the AES data-output register and sent to a sink stream.
- Sits between the system stream fabric and the AES APB slave port, in place of a CPU doing programmed I/O.

Parameters:
- DIN_ADDR, 32'h0000_0008: APB byte address of the AES data-input register.
- DOUT_ADDR, 32'h0000_000C: APB byte address of the AES data-output register.
- BLOCK_WORDS, 4: APB transfers per DMA request (one AES block).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous reset, active-high
- enable  in  1  master enable; when 0, no new burst starts
- dma_req  in  2  bit1 = write request (AES wants input), bit0 = read request (AES has output); level signals
- src_valid  in  1  source word available
- src_data  in  32  source word
- src_ready  out  1  source word consumed this cycle
- dst_valid  out  1  sink word held
- dst_data  out  32  sink word
- dst_ready  in  1  sink accepts the word
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error
- busy  out  1  burst in progress
- err  out  1  sticky error flag; cleared by reset or by err_clr
- err_clr  in  1  clears err

Behaviour:
Reset values: all outputs 0. FSM = IDLE. Word counter = 0.

FSM states: IDLE, WAIT_SRC, SETUP, ACCESS, WAIT_DST.

IDLE:
- Leaves IDLE only when enable=1 and err=0.
- dma_req[0] set -> load RD, PADDR=DOUT_ADDR, go to SETUP. Read has priority over write, so the output is drained before new input.
- Else dma_req[1] set -> load WR, go to WAIT_SRC.
- busy=1 in every state except IDLE.

WAIT_SRC:
- On src_valid=1: src_ready pulses for 1 cycle, PWDATA<=src_data, PADDR=DIN_ADDR, go to SETUP.

SETUP:
- PSEL=1, PENABLE=0, PWRITE=WR.
- Go to ACCESS unconditionally.

ACCESS:
- PSEL=1, PENABLE=1.
- Hold PADDR, PWDATA and PWRITE stable while PREADY=0.
- On PREADY=1 and PSLVERR=1: err<=1, drop PSEL/PENABLE, counter<=0, go to IDLE. The burst is aborted and no stream handshake occurs for that word.
- On PREADY=1 and PSLVERR=0, write: counter++. If counter reaches BLOCK_WORDS, clear it and go to IDLE; else go to WAIT_SRC.
- On PREADY=1 and PSLVERR=0, read: dst_data<=PRDATA, dst_valid<=1, go to WAIT_DST.
- PSEL and PENABLE deassert in the cycle after completion.

WAIT_DST:
- On dst_ready=1: dst_valid<=0, counter++.
- If count complete, go to IDLE; else go to SETUP with PADDR=DOUT_ADDR.
- dst_valid/dst_data hold stable until accepted.

General rules:
- Minimum APB transfer: 2 cycles. Minimum burst of 4 writes with src_valid held at 1: 12 cycles (WAIT_SRC, SETUP, ACCESS per word). Idle-to-first-PSEL latency: 1 cycle for reads, 2 for writes.
- dma_req is sampled only in IDLE. Deassertion mid-burst does not abort the burst.
- enable=0 mid-burst: the current burst completes, then the FSM stays in IDLE.
- err_clr and an error in the same cycle: set wins.
- Counter is log2(BLOCK_WORDS)+1 bits and never wraps; it is cleared at burst end or abort.
- PRESET mid-transfer: PSEL/PENABLE drop immediately (asynchronously), and any held dst word is discarded.
- Only single transfers; PADDR is constant per direction (register address, no increment).

Test Plan:
- dma_req=2'b10, src streams 0x11111111..0x44444444 with src_valid held at 1, PREADY=1 -> 4 APB writes to 0x08 with those PWDATA values in order; 4 src_ready pulses; busy high for 12 cycles; back to IDLE.
- dma_req=2'b01, PRDATA returns 0xA0..0xA3, dst_ready=1 -> 4 reads of 0x0C; dst_data emits 0xA0..0xA3 in order; no write transfers.
- dma_req=2'b11 in IDLE -> read burst executes first; write burst starts only after the read burst completes and dma_req[1] is still high.
- PREADY held at 0 for 3 cycles in ACCESS -> PADDR, PWDATA, PSEL and PENABLE stay stable; transfer completes in the cycle PREADY=1.
- PSLVERR=1 on word 2 of a write burst -> err=1, PSEL drops next cycle, only 2 src words consumed; new dma_req is ignored until err_clr.
- PRESET asserted during ACCESS with dst_ready=0 from the previous read word -> all outputs 0 asynchronously; after release, a fresh read burst restarts at word 0.

Source files
------------

// File: rtl/aes_apb_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : aes_apb_dma_master
// Purpose  : APB requester servicing the AES DMA request pair. Each request
//            moves one AES block as BLOCK_WORDS single 32-bit APB transfers:
//            writes take words from a source stream into the AES data-input
//            register, reads take words from the AES data-output register
//            out to a sink stream.
// Ports    : PCLK, PRESET (async, active-high)
//            enable, dma_req[1:0] (bit1 write request, bit0 read request)
//            src_valid/src_data/src_ready : source stream (write direction)
//            dst_valid/dst_data/dst_ready : sink stream (read direction)
//            PADDR/PWDATA/PWRITE/PSEL/PENABLE/PRDATA/PREADY/PSLVERR : APB
//            busy, err (sticky), err_clr
// Revision : 1.0 - initial release
// ============================================================================
module aes_apb_dma_master #(
    parameter logic [31:0] DIN_ADDR    = 32'h0000_0008,
    parameter logic [31:0] DOUT_ADDR   = 32'h0000_000C,
    parameter int          BLOCK_WORDS = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        enable,
    input  logic [1:0]  dma_req,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        dst_valid,
    output logic [31:0] dst_data,
    input  logic        dst_ready,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int             CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_SRC = 3'd1;
    localparam logic [2:0] S_SETUP    = 3'd2;
    localparam logic [2:0] S_ACCESS   = 3'd3;
    localparam logic [2:0] S_WAIT_DST = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             wr;          // direction of the burst in progress
    logic [CNT_W-1:0] count;       // words completed in this burst
    logic             last_word;
    logic             can_start;

    assign last_word = (count == LAST_WORD);
    assign can_start = enable && !err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                // Read first so pending AES output is drained before new input.
                if (can_start && dma_req[0]) begin
                    state_next = S_SETUP;
                end else if (can_start && dma_req[1]) begin
                    state_next = S_WAIT_SRC;
                end
            end
            S_WAIT_SRC: begin
                if (src_valid) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                state_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_next = S_IDLE;
                    end else if (wr) begin
                        state_next = last_word ? S_IDLE : S_WAIT_SRC;
                    end else begin
                        state_next = S_WAIT_DST;
                    end
                end
            end
            S_WAIT_DST: begin
                if (dst_ready) begin
                    state_next = last_word ? S_IDLE : S_SETUP;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. PSEL/PENABLE come straight from the state so that a
    // reset removes them without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        src_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_WAIT_SRC: begin
                src_ready = src_valid;
            end
            S_SETUP: begin
                PSEL   = 1'b1;
                PWRITE = wr;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PWRITE  = wr;
            end
            S_WAIT_DST: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address/data holding registers, word counter, sink word
    // and sticky error flag.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr        <= 1'b0;
            count     <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            dst_valid <= 1'b0;
            dst_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (can_start && dma_req[0]) begin
                        wr    <= 1'b0;
                        PADDR <= DOUT_ADDR;
                    end else if (can_start && dma_req[1]) begin
                        wr <= 1'b1;
                    end
                end
                S_WAIT_SRC: begin
                    if (src_valid) begin
                        PWDATA <= src_data;
                        PADDR  <= DIN_ADDR;
                    end
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        if (PSLVERR) begin
                            // Placed after err_clr so a simultaneous set wins.
                            err   <= 1'b1;
                            count <= '0;
                        end else if (wr) begin
                            count <= last_word ? '0 : count + CNT_W'(1);
                        end else begin
                            dst_data  <= PRDATA;
                            dst_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT_DST: begin
                    if (dst_ready) begin
                        dst_valid <= 1'b0;
                        count     <= last_word ? '0 : count + CNT_W'(1);
                        PADDR     <= DOUT_ADDR;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
